// File: rtl/fll_clk_gate_pkg.sv
// Shared types and default timing for the FLL-domain clock-gate controller.
package fll_clk_gate_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, OFF, WAKE} fll_cg_state_e;

    localparam int unsigned DEF_IDLE_CYCLES = 4;
    localparam int unsigned DEF_WAKE_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fll_cg_timer.sv
// Clearable up-counter with terminal-count compare; holds at the terminal value.
module fll_cg_timer
    import fll_clk_gate_pkg::*;
#(
    parameter int unsigned TW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [TW-1:0] tc_val_i,
    output logic          tc_o
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !tc_o) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign tc_o = (r_cnt == tc_val_i);

endmodule

// File: rtl/fll_clk_gate_ctrl.sv
// Clock-gate enable controller with req/ack handshake, idle drain and wake settle.
// Define FLL_CG_STATS_EN to add the saturating gated-cycle counter (stats_clr_i, gated_cycles_o).
module fll_clk_gate_ctrl
    import fll_clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES
`ifdef FLL_CG_STATS_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             gate_req_i,
    input  logic             idle_i,
    output logic             cg_en_o,
    output logic             gate_ack_o,
    output logic             busy_o
`ifdef FLL_CG_STATS_EN
    ,
    input  logic             stats_clr_i,
    output logic [CNT_W-1:0] gated_cycles_o
`endif
);

    localparam int unsigned   TW      = $clog2(max_u(IDLE_CYCLES, WAKE_CYCLES) + 1);
    localparam logic [TW-1:0] IDLE_TC = TW'(IDLE_CYCLES - 1);
    localparam logic [TW-1:0] WAKE_TC = TW'(WAKE_CYCLES - 1);

    fll_cg_state_e r_state, w_state_d;
    logic          w_tmr_clr, w_tmr_en, w_tmr_tc;
    logic [TW-1:0] w_tc_val;
    logic          r_cg_en, r_ack, r_busy;

    fll_cg_timer #(
        .TW (TW)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (w_tmr_clr),
        .en_i     (w_tmr_en),
        .tc_val_i (w_tc_val),
        .tc_o     (w_tmr_tc)
    );

    always_comb begin
        w_state_d = r_state;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;
        w_tc_val  = IDLE_TC;
        unique case (r_state)
            RUN: begin
                w_tmr_clr = 1'b1;
                if (gate_req_i) w_state_d = DRAIN;
            end
            DRAIN: begin
                // Abort takes priority over a coincident final idle cycle.
                if (!gate_req_i) begin
                    w_state_d = RUN;
                    w_tmr_clr = 1'b1;
                end else if (!idle_i) begin
                    w_tmr_clr = 1'b1;
                end else if (w_tmr_tc) begin
                    w_state_d = OFF;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            OFF: begin
                w_tmr_clr = 1'b1;
                if (!gate_req_i) w_state_d = WAKE;
            end
            WAKE: begin
                w_tc_val = WAKE_TC;
                if (w_tmr_tc) begin
                    w_state_d = RUN;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: w_state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RUN;
            r_cg_en <= 1'b1;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // Outputs decode the current state, so they trail it by one edge.
            r_cg_en <= (r_state != OFF);
            r_ack   <= (r_state == OFF) || (r_state == WAKE);
            r_busy  <= (r_state == DRAIN) || (r_state == WAKE);
        end
    end

    assign cg_en_o    = r_cg_en;
    assign gate_ack_o = r_ack;
    assign busy_o     = r_busy;

`ifdef FLL_CG_STATS_EN
    logic [CNT_W-1:0] r_gated;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gated <= '0;
        end else if (stats_clr_i) begin
            r_gated <= '0;
        end else if ((r_state == OFF) && (r_gated != '1)) begin
            r_gated <= r_gated + CNT_W'(1);
        end
    end

    assign gated_cycles_o = r_gated;
`endif

endmodule

// File: tb/tb_fll_clk_gate_ctrl.sv
// Directed bench for fll_clk_gate_ctrl; stats checks run when FLL_CG_STATS_EN is defined.
module tb_fll_clk_gate_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic req, idle;
    logic cg_en, ack, busy;
`ifdef FLL_CG_STATS_EN
    logic       stats_clr;
    logic [3:0] gated;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

`ifdef FLL_CG_STATS_EN
    fll_clk_gate_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2),
        .CNT_W       (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .gate_req_i     (req),
        .idle_i         (idle),
        .cg_en_o        (cg_en),
        .gate_ack_o     (ack),
        .busy_o         (busy),
        .stats_clr_i    (stats_clr),
        .gated_cycles_o (gated)
    );
`else
    fll_clk_gate_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .gate_req_i (req),
        .idle_i     (idle),
        .cg_en_o    (cg_en),
        .gate_ack_o (ack),
        .busy_o     (busy)
    );
`endif

    typedef struct {
        logic       req;
        logic       idle;
        logic [2:0] exp;  // {cg_en, ack, busy} after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Inputs change just after a falling edge, are sampled on the next rising edge,
    // and outputs are observed on the following falling edge.
    task automatic step(input logic r, input logic i);
        req  = r;
        idle = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic r, input logic i, input logic [2:0] e);
        vecs.push_back('{r, i, e});
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        idle  = 1'b1;
`ifdef FLL_CG_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_outputs", {29'd0, cg_en, ack, busy}, 32'h4);
`ifdef FLL_CG_STATS_EN
        check("reset_gated", {28'd0, gated}, 32'd0);
`endif
        rst_n = 1'b1;

        // Idle with no request: clock stays on.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1);
            check("idle_run", {29'd0, cg_en, ack, busy}, 32'h4);
        end

        // Gate with idle held, then wake.
        add(0,1,3'b100); add(0,1,3'b100); add(1,1,3'b100); add(1,1,3'b101);
        add(1,1,3'b101); add(1,1,3'b101); add(1,1,3'b101); add(1,1,3'b010);
        add(1,0,3'b010); add(0,0,3'b010); add(0,1,3'b111); add(0,1,3'b111);
        add(0,1,3'b100); add(0,1,3'b100);
        // Idle drop mid-drain restarts the count.
        add(1,1,3'b100); add(1,1,3'b101); add(1,1,3'b101); add(1,0,3'b101);
        add(1,1,3'b101); add(1,1,3'b101); add(1,1,3'b101); add(1,1,3'b101);
        add(1,1,3'b010); add(0,1,3'b010); add(0,1,3'b111); add(0,1,3'b111);
        add(0,1,3'b100);
        // Abort after two idle cycles.
        add(1,1,3'b100); add(1,1,3'b101); add(1,1,3'b101); add(0,1,3'b101);
        add(0,1,3'b100); add(0,1,3'b100);
        // Abort coincident with the final idle cycle.
        add(1,1,3'b100); add(1,1,3'b101); add(1,1,3'b101); add(1,1,3'b101);
        add(0,1,3'b101); add(0,1,3'b100); add(0,1,3'b100);

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].idle);
            check($sformatf("vec%0d", i), {29'd0, cg_en, ack, busy}, {29'd0, vecs[i].exp});
        end

        // Re-request during wake: wake completes, then a fresh drain.
        for (int k = 0; k < 20 && !ack; k++) step(1'b1, 1'b1);
        check("enter_off", {31'd0, ack}, 32'd1);
        step(1'b0, 1'b1);
        check("wake_m", {29'd0, cg_en, ack, busy}, 32'h2);
        step(1'b1, 1'b1);
        check("wake_m1", {29'd0, cg_en, ack, busy}, 32'h7);
        step(1'b1, 1'b1);
        check("wake_m2", {29'd0, cg_en, ack, busy}, 32'h7);
        step(1'b1, 1'b1);
        check("wake_m3", {29'd0, cg_en, ack, busy}, 32'h4);
        step(1'b1, 1'b1);
        check("redrain_m4", {29'd0, cg_en, ack, busy}, 32'h5);
        repeat (3) step(1'b1, 1'b1);
        check("redrain_m7", {29'd0, cg_en, ack, busy}, 32'h5);
        step(1'b1, 1'b1);
        check("regate_m8", {29'd0, cg_en, ack, busy}, 32'h2);

`ifdef FLL_CG_STATS_EN
        repeat (20) step(1'b1, 1'b1);
        check("gated_sat", {28'd0, gated}, 32'd15);
        stats_clr = 1'b1;
        step(1'b1, 1'b1);
        stats_clr = 1'b0;
        check("gated_clr", {28'd0, gated}, 32'd0);
        step(1'b1, 1'b1);
        check("gated_inc", {28'd0, gated}, 32'd1);
        step(1'b1, 1'b1);
`endif

        // Asynchronous reset while gated.
        rst_n = 1'b0;
        #1;
        check("async_rst", {29'd0, cg_en, ack, busy}, 32'h4);
`ifdef FLL_CG_STATS_EN
        check("async_rst_gated", {28'd0, gated}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        check("post_rst", {29'd0, cg_en, ack, busy}, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
